// File: rtl/count_bcd_converter_if.sv
// Start/busy/done bundle between the counter-side producer and the BCD converter.
interface count_bcd_converter_if #(
    parameter int WIDTH = 7
);
    logic             start;
    logic [WIDTH-1:0] bin_in;
    logic             busy;
    logic             done;
    logic [3:0]       bcd_hundreds;
    logic [3:0]       bcd_tens;
    logic [3:0]       bcd_ones;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_hundreds, bcd_tens, bcd_ones
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_hundreds, bcd_tens, bcd_ones
    );
endinterface

// File: rtl/count_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter: one shift per clock,
// WIDTH shifts, then a single LOAD cycle that publishes the three digits.
module count_bcd_converter #(
    parameter int WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    count_bcd_converter_if.slave  bus,
    output logic [1:0]            dbg_state
);
    // Handshake: start is accepted only on an edge where the converter is
    // IDLE (busy=0); bin_in is captured on that edge only. busy stays high
    // through SHIFT and LOAD, starts arriving meanwhile are dropped, and done
    // pulses for exactly one cycle when the new digits appear.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [11:0]      scratch_q, scratch_d;
    logic [11:0]      scratch_adj;
    logic [11+WIDTH:0] shifted;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [11:0]      bcd_q, bcd_d;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;

        // All three digits are corrected from their pre-shift values.
        scratch_adj = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};
        shifted     = {scratch_adj, shreg_q} << 1;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    shreg_d   = bus.bin_in;
                    scratch_d = '0;
                    cnt_d     = CW'(WIDTH);
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = shifted[11+WIDTH:WIDTH];
                shreg_d   = shifted[WIDTH-1:0];
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                bcd_d   = scratch_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            scratch_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.bcd_hundreds = bcd_q[11:8];
    assign bus.bcd_tens     = bcd_q[7:4];
    assign bus.bcd_ones     = bcd_q[3:0];
    assign dbg_state        = state_q;
endmodule

// File: tb/tb_count_bcd_converter.sv
// Directed and randomized checks of count_bcd_converter against a decimal-arithmetic reference.
module tb_count_bcd_converter;
    localparam int WIDTH = 7;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;

    count_bcd_converter_if #(.WIDTH(WIDTH)) bus ();

    count_bcd_converter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    logic [11:0] exp_q[$];

    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    function automatic logic [11:0] bcd_ref(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] digits();
        return {bus.bcd_hundreds, bus.bcd_tens, bus.bcd_ones};
    endfunction

    // mode 0: quiet inputs, 1: random start/bin_in noise while busy, 2: start with bin_in=5 at N+3
    task automatic convert(input int v, input int mode);
        int c0;
        logic [11:0] expd;
        c0 = done_cnt;
        bus.bin_in = WIDTH'(v);
        bus.start  = 1'b1;
        exp_q.push_back(bcd_ref(v));
        step();
        check("busy_on_accept", bus.busy, 1);
        check("done_low_accept", bus.done, 0);
        bus.start = 1'b0;
        for (int i = 1; i <= WIDTH + 1; i++) begin
            if (mode == 1) begin
                bus.start  = 1'($urandom_range(0, 1));
                bus.bin_in = WIDTH'($urandom);
            end else if (mode == 2) begin
                bus.start  = (i == 3);
                bus.bin_in = (i == 3) ? WIDTH'(5) : WIDTH'(v);
            end
            step();
            if (i <= WIDTH) begin
                check("busy_during", bus.busy, 1);
                check("done_during", bus.done, 0);
            end else begin
                expd = exp_q.pop_front();
                check("done_pulse", bus.done, 1);
                check("busy_at_done", bus.busy, 0);
                check("digits", digits(), expd);
            end
        end
        bus.start  = 1'b0;
        bus.bin_in = WIDTH'($urandom);
        step();
        check("done_one_cycle", bus.done, 0);
        check("busy_after", bus.busy, 0);
        check("digits_hold", digits(), expd);
        check("done_count", done_cnt - c0, 1);
    endtask

    initial begin
        int c0;
        int cnt;
        logic [11:0] expd;

        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        step();
        step();
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_digits", digits(), 0);
        reset = 1'b0;
        step();

        convert(127, 0);
        convert(0, 0);
        convert(99, 0);
        convert(100, 0);
        convert(127, 2);

        // Reset four edges into a conversion aborts it with no done.
        bus.bin_in = WIDTH'(64);
        bus.start  = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_digits", digits(), 0);
        reset = 1'b0;
        c0 = done_cnt;
        repeat (12) step();
        check("abort_no_done", done_cnt - c0, 0);
        check("abort_idle_busy", bus.busy, 0);

        // Reset and start on the same edge: start is lost.
        reset      = 1'b1;
        bus.start  = 1'b1;
        bus.bin_in = WIDTH'(55);
        step();
        reset     = 1'b0;
        bus.start = 1'b0;
        step();
        check("reset_start_busy", bus.busy, 0);
        c0 = done_cnt;
        repeat (10) step();
        check("reset_start_no_done", done_cnt - c0, 0);

        // Start held high while a down-counter feeds bin_in: one result every WIDTH+2 cycles.
        cnt = 127;
        bus.start = 1'b1;
        for (int k = 0; k < 9 * 20; k++) begin
            bus.bin_in = WIDTH'(cnt);
            if (k % (WIDTH + 2) == 0) exp_q.push_back(bcd_ref(cnt));
            step();
            if (k % (WIDTH + 2) == WIDTH + 1) begin
                expd = exp_q.pop_front();
                check("stream_done", bus.done, 1);
                check("stream_digits", digits(), expd);
            end else begin
                check("stream_no_done", bus.done, 0);
            end
            cnt = (cnt == 0) ? 127 : cnt - 1;
        end
        bus.start = 1'b0;
        repeat (WIDTH + 3) step();
        exp_q.delete();

        for (int v = 0; v < 128; v++) convert(v, 0);
        for (int r = 0; r < 40; r++) begin
            convert(int'($urandom_range(0, 127)), 1);
            repeat ($urandom_range(0, 3)) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
